// File: rtl/preif_fetch_queue.sv
// Pre-IF fetch controller: generates fetch PCs, keeps up to DEPTH outstanding
// inst_sram requests in an in-order queue and drops returns made stale by redirects.
module preif_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  input  logic        ertn_flush,
  input  logic [31:0] ex_ra,
  input  logic        br_taken_cancel,
  input  logic [31:0] br_target,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_ex
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Encoding order doubles as priority order: larger value wins.
  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_BR   = 2'd1,
    KIND_ERTN = 2'd2,
    KIND_EX   = 2'd3
  } redir_kind_e;

  redir_kind_e        pend_kind_r;
  logic [31:0]        pend_tgt_r;
  logic [31:0]        last_pc_r;
  logic [PTR_W-1:0]   head_ptr_r;
  logic [PTR_W-1:0]   tail_ptr_r;
  logic [CNT_W-1:0]   count_r;

  logic [31:0]        ent_pc_r   [DEPTH];
  logic [31:0]        ent_inst_r [DEPTH];
  logic [DEPTH-1:0]   ent_done_r;
  logic [DEPTH-1:0]   ent_stale_r;
  logic [DEPTH-1:0]   ent_ex_r;

  redir_kind_e        cur_kind_s;
  logic [31:0]        cur_tgt_s;
  logic               take_cur_s;
  logic               redirect_any_s;
  logic [31:0]        next_pc_s;
  logic               aligned_s;
  logic               full_s;
  logic               push_s;
  logic               pop_s;
  logic               head_done_s;
  logic               head_stale_s;
  logic               ret_hit_s;
  logic [PTR_W-1:0]   ret_idx_s;
  logic [PTR_W-1:0]   scan_idx_s;
  logic               ret_done_s;

  // Same-cycle redirect source selection by fixed priority
  always_comb begin
    cur_kind_s = KIND_NONE;
    cur_tgt_s  = 32'h0;
    if (wb_ex) begin
      cur_kind_s = KIND_EX;
      cur_tgt_s  = ex_entry;
    end else if (ertn_flush) begin
      cur_kind_s = KIND_ERTN;
      cur_tgt_s  = ex_ra;
    end else if (br_taken_cancel) begin
      cur_kind_s = KIND_BR;
      cur_tgt_s  = br_target;
    end else begin
      cur_kind_s = KIND_NONE;
      cur_tgt_s  = 32'h0;
    end
  end

  assign redirect_any_s = wb_ex | ertn_flush | br_taken_cancel;
  assign take_cur_s     = (cur_kind_s != KIND_NONE) && (cur_kind_s >= pend_kind_r);

  // Next fetch PC: winning redirect, else held redirect, else sequential
  always_comb begin
    next_pc_s = last_pc_r + 32'd4;
    if (take_cur_s) begin
      next_pc_s = cur_tgt_s;
    end else if (pend_kind_r != KIND_NONE) begin
      next_pc_s = pend_tgt_r;
    end else begin
      next_pc_s = last_pc_r + 32'd4;
    end
  end

  assign aligned_s      = (next_pc_s[1:0] == 2'b00);
  assign full_s         = (count_r == CNT_FULL);
  assign inst_sram_req  = resetn && !full_s && aligned_s;
  assign inst_sram_addr = {next_pc_s[31:2], 2'b00};
  // A misaligned PC allocates an ADEF entry without touching the SRAM.
  assign push_s         = !full_s && (aligned_s ? inst_sram_addr_ok : 1'b1);

  assign head_done_s  = (count_r != {CNT_W{1'b0}}) && ent_done_r[head_ptr_r];
  assign head_stale_s = ent_stale_r[head_ptr_r];
  assign pop_s        = head_done_s && (head_stale_s || if_ready);

  assign if_valid = head_done_s && !head_stale_s;
  assign if_pc    = if_valid ? ent_pc_r[head_ptr_r]   : 32'h0;
  assign if_inst  = if_valid ? ent_inst_r[head_ptr_r] : 32'h0;
  assign if_ex    = if_valid ? ent_ex_r[head_ptr_r]   : 1'b0;

  // Locate the oldest undone entry, the one the next data_ok belongs to
  always_comb begin
    ret_hit_s  = 1'b0;
    ret_idx_s  = {PTR_W{1'b0}};
    scan_idx_s = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx_s = head_ptr_r + PTR_W'(i);
      if (!ret_hit_s && (CNT_W'(i) < count_r) && !ent_done_r[scan_idx_s]) begin
        ret_hit_s = 1'b1;
        ret_idx_s = scan_idx_s;
      end else begin
        ret_hit_s = ret_hit_s;
      end
    end
  end

  assign ret_done_s = inst_sram_data_ok && ret_hit_s;

  // Queue pointers, occupancy, pending redirect and last fetched PC
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_kind_r <= KIND_NONE;
      pend_tgt_r  <= 32'h0;
      last_pc_r   <= RESET_PC - 32'd4;
      head_ptr_r  <= {PTR_W{1'b0}};
      tail_ptr_r  <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        pend_kind_r <= KIND_NONE;
        pend_tgt_r  <= 32'h0;
        // Keep the sequential stream word aligned after an ADEF entry.
        last_pc_r   <= {next_pc_s[31:2], 2'b00};
        tail_ptr_r  <= tail_ptr_r + PTR_W'(1);
      end else if (take_cur_s) begin
        pend_kind_r <= cur_kind_s;
        pend_tgt_r  <= cur_tgt_s;
      end
      if (pop_s) begin
        head_ptr_r <= head_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage: stale marking, in-order completion, allocation
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_r[i]   <= 32'h0;
        ent_inst_r[i] <= 32'h0;
      end
      ent_done_r  <= {DEPTH{1'b0}};
      ent_stale_r <= {DEPTH{1'b0}};
      ent_ex_r    <= {DEPTH{1'b0}};
    end else begin
      if (redirect_any_s) begin
        ent_stale_r <= {DEPTH{1'b1}};
      end
      if (ret_done_s) begin
        ent_done_r[ret_idx_s] <= 1'b1;
        ent_inst_r[ret_idx_s] <= inst_sram_rdata;
      end
      // Allocation comes last so the new entry is never marked stale.
      if (push_s) begin
        ent_pc_r[tail_ptr_r]    <= next_pc_s;
        ent_inst_r[tail_ptr_r]  <= 32'h0;
        ent_done_r[tail_ptr_r]  <= !aligned_s;
        ent_stale_r[tail_ptr_r] <= 1'b0;
        ent_ex_r[tail_ptr_r]    <= !aligned_s;
      end
    end
  end

endmodule

// File: tb/tb_preif_fetch_queue.sv
// Self-checking bench for preif_fetch_queue: directed scenarios plus random
// stimulus, all compared against a queue-level reference model.
module tb_preif_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_ex, ertn_flush, br_taken_cancel;
  logic [31:0] ex_entry, ex_ra, br_target;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        if_valid, if_ready, if_ex;
  logic [31:0] if_pc, if_inst;

  preif_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .wb_ex             (wb_ex),
    .ex_entry          (ex_entry),
    .ertn_flush        (ertn_flush),
    .ex_ra             (ex_ra),
    .br_taken_cancel   (br_taken_cancel),
    .br_target         (br_target),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .if_valid          (if_valid),
    .if_ready          (if_ready),
    .if_pc             (if_pc),
    .if_inst           (if_inst),
    .if_ex             (if_ex)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model: a plain queue of in-flight fetches
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          done;
    bit          stale;
    bit          ex;
  } ent_t;

  ent_t        mq[$];
  int          m_pend_kind;
  logic [31:0] m_pend_tgt;
  logic [31:0] m_last;

  int          accepts;
  logic [31:0] seen_pc[$];
  bit          seen_ex[$];

  task automatic m_reset();
    mq.delete();
    m_pend_kind = 0;
    m_pend_tgt  = 32'h0;
    m_last      = RESET_PC - 32'd4;
  endtask

  function automatic logic [31:0] seen_at(input int i);
    if (i < seen_pc.size()) return seen_pc[i];
    else return 32'hDEAD_BEEF;
  endfunction

  task automatic idle_inputs();
    wb_ex = 1'b0; ertn_flush = 1'b0; br_taken_cancel = 1'b0;
    ex_entry = 32'h0; ex_ra = 32'h0; br_target = 32'h0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
    inst_sram_rdata = 32'h0; if_ready = 1'b0;
  endtask

  // Entered at a negedge with inputs applied; checks, advances model, returns at next negedge.
  task automatic step();
    int          ck;
    logic [31:0] ct, npc, hpc, hinst;
    bit          full, valid, push, pop, hit, hex;
    ent_t        e;
    #1;
    ck = wb_ex ? 3 : ertn_flush ? 2 : br_taken_cancel ? 1 : 0;
    ct = wb_ex ? ex_entry : ertn_flush ? ex_ra : br_target;
    if (ck != 0 && ck >= m_pend_kind) npc = ct;
    else if (m_pend_kind != 0)        npc = m_pend_tgt;
    else                              npc = m_last + 32'd4;
    full  = (mq.size() == DEPTH);
    valid = (mq.size() > 0) && mq[0].done && !mq[0].stale;
    hpc   = valid ? mq[0].pc : 32'h0;
    hinst = valid ? mq[0].inst : 32'h0;
    hex   = valid ? mq[0].ex : 1'b0;
    check_val("req", 32'(inst_sram_req), 32'(resetn && !full && npc[1:0] == 2'b00));
    check_val("addr", inst_sram_addr, {npc[31:2], 2'b00});
    check_val("if_valid", 32'(if_valid), 32'(valid));
    check_val("if_pc", if_pc, hpc);
    check_val("if_inst", if_inst, hinst);
    check_val("if_ex", 32'(if_ex), 32'(hex));
    if (resetn) begin
      if (if_valid && if_ready) begin
        seen_pc.push_back(if_pc);
        seen_ex.push_back(if_ex);
      end
      if (inst_sram_req && inst_sram_addr_ok) accepts++;
      pop  = (mq.size() > 0) && mq[0].done && (mq[0].stale || if_ready);
      push = !full && (npc[1:0] != 2'b00 || inst_sram_addr_ok);
      if (inst_sram_data_ok) begin
        hit = 1'b0;
        for (int i = 0; i < mq.size(); i++) begin
          if (!hit && !mq[i].done) begin
            mq[i].done = 1'b1;
            mq[i].inst = inst_sram_rdata;
            hit = 1'b1;
          end
        end
      end
      if (ck != 0) begin
        for (int i = 0; i < mq.size(); i++) mq[i].stale = 1'b1;
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc    = npc;
        e.ex    = (npc[1:0] != 2'b00);
        e.done  = e.ex;
        e.stale = 1'b0;
        e.inst  = 32'h0;
        mq.push_back(e);
        m_pend_kind = 0;
        m_last      = {npc[31:2], 2'b00};
      end else if (ck != 0 && ck >= m_pend_kind) begin
        m_pend_kind = ck;
        m_pend_tgt  = ct;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    m_reset();
    step();
    step();
    resetn = 1'b1;
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = 32'h1C00_0000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  initial begin
    idle_inputs();
    resetn = 1'b0;
    m_reset();
    @(negedge clk);
    do_reset();

    // Sequential fetch with 1-cycle SRAM
    seen_pc.delete();
    inst_sram_addr_ok = 1'b1; inst_sram_data_ok = 1'b1; if_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      inst_sram_rdata = $urandom;
      step();
    end
    check_val("t1_n", 32'(seen_pc.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) check_val("t1_pc", seen_at(i), RESET_PC + 32'(4 * i));

    // Fill to DEPTH with no returns, then drain
    do_reset();
    accepts = 0;
    inst_sram_addr_ok = 1'b1;
    for (int c = 0; c < 8; c++) step();
    check_val("t2_accepts", 32'(accepts), 32'd4);
    #1 check_val("t2_req_full", 32'(inst_sram_req), 32'd0);
    seen_pc.delete();
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; if_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      inst_sram_rdata = $urandom;
      step();
    end
    check_val("t2_n", 32'(seen_pc.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_val("t2_pc", seen_at(i), RESET_PC + 32'(4 * i));

    // Branch with 3 outstanding drops their returns
    do_reset();
    inst_sram_addr_ok = 1'b1; if_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    seen_pc.delete();
    br_taken_cancel = 1'b1; br_target = 32'h1C00_0100;
    step();
    br_taken_cancel = 1'b0; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      inst_sram_rdata = $urandom;
      step();
    end
    check_val("t3_n", 32'(seen_pc.size()), 32'd1);
    check_val("t3_pc", seen_at(0), 32'h1C00_0100);

    // Exception beats branch; held exception beats a later branch
    do_reset();
    wb_ex = 1'b1; ex_entry = 32'h1C00_8000;
    br_taken_cancel = 1'b1; br_target = 32'h1C00_0200;
    step();
    wb_ex = 1'b0; br_taken_cancel = 1'b0;
    #1 check_val("t4_pend", inst_sram_addr, 32'h1C00_8000);
    step();
    br_taken_cancel = 1'b1; br_target = 32'h1C00_0300;
    #1 check_val("t4_br_ign", inst_sram_addr, 32'h1C00_8000);
    step();
    br_taken_cancel = 1'b0; inst_sram_addr_ok = 1'b1;
    step();
    inst_sram_addr_ok = 1'b0;
    #1 check_val("t4_next", inst_sram_addr, 32'h1C00_8004);
    step();

    // Misaligned branch target raises ADEF without an SRAM request
    do_reset();
    inst_sram_addr_ok = 1'b1;
    br_taken_cancel = 1'b1; br_target = 32'h1C00_0102;
    #1 check_val("t5_noreq", 32'(inst_sram_req), 32'd0);
    step();
    br_taken_cancel = 1'b0; inst_sram_addr_ok = 1'b0;
    #1;
    check_val("t5_valid", 32'(if_valid), 32'd1);
    check_val("t5_ex", 32'(if_ex), 32'd1);
    check_val("t5_pc", if_pc, 32'h1C00_0102);
    check_val("t5_inst", if_inst, 32'h0);
    check_val("t5_addr", inst_sram_addr, 32'h1C00_0104);
    check_val("t5_req", 32'(inst_sram_req), 32'd1);
    step();

    // Asynchronous reset with 2 outstanding; late data_ok ignored
    do_reset();
    inst_sram_addr_ok = 1'b1;
    step();
    step();
    inst_sram_addr_ok = 1'b0;
    resetn = 1'b0;
    #1;
    check_val("t6_req", 32'(inst_sram_req), 32'd0);
    check_val("t6_valid", 32'(if_valid), 32'd0);
    check_val("t6_pc", if_pc, 32'h0);
    check_val("t6_inst", if_inst, 32'h0);
    check_val("t6_ex", 32'(if_ex), 32'd0);
    m_reset();
    step();
    step();
    resetn = 1'b1;
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h1234_5678;
    #1 check_val("t6_first", inst_sram_addr, RESET_PC);
    step();
    inst_sram_data_ok = 1'b0; inst_sram_addr_ok = 1'b1; if_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      wb_ex             = ($urandom_range(0, 99) < 2);
      ertn_flush        = ($urandom_range(0, 99) < 3);
      br_taken_cancel   = ($urandom_range(0, 99) < 6);
      ex_entry          = rand_tgt();
      ex_ra             = rand_tgt();
      br_target         = rand_tgt();
      inst_sram_addr_ok = ($urandom_range(0, 1) == 1);
      inst_sram_data_ok = ($urandom_range(0, 99) < 60);
      inst_sram_rdata   = $urandom;
      if_ready          = ($urandom_range(0, 99) < 70);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
